// File: rtl/game_pkg.sv
// Shared motion types and default screen/sprite geometry for the player controllers and draw modules.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    JUMP,
    FALL
  } motion_state_t;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;
  localparam int CNT_W    = 24;

endpackage

// File: rtl/motion_step_timer.sv
// Step-rate counter: counts 0..limit-1 while enabled, pulses step on the terminal count.
module motion_step_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             step
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic             at_limit;

  assign at_limit = (count == limit - ONE);
  assign step     = enable && !clear && at_limit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_limit ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player movement controller: key levels and collision flags to registered sprite coordinates.
// Optional build macro PLAYER_MOTION_EDGE_CLAMP_EN clamps x to the screen; otherwise x wraps.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int X_SPAWN     = 500,
  parameter int Y_SPAWN     = 400,
  parameter int PLAYER_W    = SPRITE_W,
  parameter int PLAYER_H    = SPRITE_H,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - 1,
  parameter int Y_FLOOR     = SCREEN_H - 1,
  parameter int JUMP_HEIGHT = 100,
  parameter int STEP_DIV    = 500_000,
  parameter int Y_DIV_START = 500_000,
  parameter int Y_DIV_DELTA = 10_000,
  parameter int Y_DIV_MIN   = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               left,
  input  logic               right,
  input  logic               jump,
  input  logic               respawn,
  input  logic               on_ground,
  input  logic               head_hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               airborne,
  output logic               facing
);

  localparam logic [COORD_W-1:0] X_SP   = COORD_W'(X_SPAWN);
  localparam logic [COORD_W-1:0] Y_SP   = COORD_W'(Y_SPAWN);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_FLOOR - PLAYER_H);
  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(X_MAX - PLAYER_W + 1);
  localparam logic [COORD_W-1:0] JUMP_H = COORD_W'(JUMP_HEIGHT);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  localparam logic [CNT_W-1:0] STEP_LIM  = CNT_W'(STEP_DIV);
  localparam logic [CNT_W-1:0] DIV_START = CNT_W'(Y_DIV_START);
  localparam logic [CNT_W-1:0] DIV_DELTA = CNT_W'(Y_DIV_DELTA);
  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(Y_DIV_MIN);

  motion_state_t      state;
  logic               jump_q;
  logic [COORD_W-1:0] y_start;
  logic [CNT_W-1:0]   ydiv;
  logic [CNT_W-1:0]   ydiv_up;
  logic [CNT_W-1:0]   ydiv_dn;
  logic [CNT_W:0]     up_sum;
  logic [COORD_W-1:0] rise;
  logic dir_valid, jump_rise, in_air, jump_end, land;
  logic x_clear, y_clear, x_step, y_step, x_block;

  assign dir_valid = left ^ right;
  assign jump_rise = jump & ~jump_q;
  assign in_air    = (state == JUMP) || (state == FALL);
  // Unsigned distance climbed so far; never formed as y_start - JUMP_HEIGHT, which could underflow.
  assign rise      = y_start - y;
  assign jump_end  = (rise >= JUMP_H) || head_hit || (y == '0);
  assign land      = on_ground || (y >= Y_LIM);

  assign x_clear = respawn || (state == IDLE) || !dir_valid;
  assign y_clear = respawn || !in_air || ((state == JUMP) && jump_end) || ((state == FALL) && land);

  assign up_sum  = {1'b0, ydiv} + {1'b0, DIV_DELTA};
  assign ydiv_up = up_sum[CNT_W] ? '1 : up_sum[CNT_W-1:0];
  assign ydiv_dn = ({1'b0, ydiv} >= ({1'b0, DIV_MIN} + {1'b0, DIV_DELTA})) ? ydiv - DIV_DELTA : DIV_MIN;

`ifdef PLAYER_MOTION_EDGE_CLAMP_EN
  assign x_block = (right && (x == X_HI)) || (left && (x == X_LO));
`else
  // Edge limits are only consumed when clamping is built in.
  logic unused_clamp;
  assign unused_clamp = ^{X_LO, X_HI};
  assign x_block      = 1'b0;
`endif

  motion_step_timer u_x_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (x_clear),
    .enable (1'b1),
    .limit  (STEP_LIM),
    .step   (x_step)
  );

  motion_step_timer u_y_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (y_clear),
    .enable (in_air),
    .limit  (ydiv),
    .step   (y_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= X_SP;
      y        <= Y_SP;
      y_start  <= Y_SP;
      ydiv     <= DIV_START;
      facing   <= 1'b0;
      airborne <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      jump_q <= jump;
      if (dir_valid) facing <= left;
      if (respawn) begin
        state    <= IDLE;
        x        <= X_SP;
        y        <= Y_SP;
        ydiv     <= DIV_START;
        airborne <= 1'b0;
      end else begin
        if (x_step && !x_block) x <= right ? x + ONE_C : x - ONE_C;
        unique case (state)
          IDLE, WALK: begin
            if (jump_rise && on_ground) begin
              state    <= JUMP;
              airborne <= 1'b1;
              y_start  <= y;
              ydiv     <= DIV_START;
            end else if (!on_ground) begin
              state    <= FALL;
              airborne <= 1'b1;
              ydiv     <= DIV_START;
            end else begin
              state <= dir_valid ? WALK : IDLE;
            end
          end
          // ydiv is carried into FALL so the descent mirrors the ascent.
          JUMP: begin
            if (jump_end) begin
              state <= FALL;
            end else if (y_step) begin
              y    <= y - ONE_C;
              ydiv <= ydiv_up;
            end
          end
          FALL: begin
            if (land) begin
              state    <= IDLE;
              airborne <= 1'b0;
              if (y > Y_LIM) y <= Y_LIM;
            end else if (y_step) begin
              y    <= y + ONE_C;
              ydiv <= ydiv_dn;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed sequences then random keys against a behavioural model.
module tb_player_motion_ctrl;

  localparam int STEP  = 4;
  localparam int YST   = 8;
  localparam int YDD   = 2;
  localparam int YMIN  = 4;
  localparam int JH    = 3;
  localparam int XSP   = 500;
  localparam int YSP   = 400;
  localparam int YLIM  = 767 - 64;
  localparam int LOW_Y = 420;
  localparam int M_IDLE = 0, M_WALK = 1, M_JUMP = 2, M_FALL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left = 1'b0, right = 1'b0, jump = 1'b0, respawn = 1'b0;
  logic on_ground = 1'b1, head_hit = 1'b0;
  logic [9:0] x, y, ex, ey;
  logic airborne, facing, eair, eface;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Reference model state: position, motion mode, cycles since last step, current vertical period.
  int mx, my, mst, mcx, mcy, mdiv, mys;
  bit mface, mjq;

  always #5 clk = ~clk;

  player_motion_ctrl #(
    .X_SPAWN(XSP), .Y_SPAWN(YSP), .JUMP_HEIGHT(JH), .STEP_DIV(STEP),
    .Y_DIV_START(YST), .Y_DIV_DELTA(YDD), .Y_DIV_MIN(YMIN)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .jump(jump), .respawn(respawn),
    .on_ground(on_ground), .head_hit(head_hit), .x(x), .y(y), .airborne(airborne), .facing(facing)
  );

  player_motion_ctrl #(
    .X_SPAWN(0), .Y_SPAWN(YSP), .JUMP_HEIGHT(JH), .STEP_DIV(STEP),
    .Y_DIV_START(YST), .Y_DIV_DELTA(YDD), .Y_DIV_MIN(YMIN)
  ) u_edge (
    .clk(clk), .rst(rst), .left(1'b1), .right(1'b0), .jump(1'b0), .respawn(1'b0),
    .on_ground(1'b1), .head_hit(1'b0), .x(ex), .y(ey), .airborne(eair), .facing(eface)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Terrain: upper floor at y=400 with an 8-pixel hole every 64 pixels, solid lower floor at y=420.
  function automatic bit ground_at(int px, int py);
    if (py == YSP) return (px % 64) >= 8;
    return py >= LOW_Y;
  endfunction

  task automatic model_reset();
    mx = XSP; my = YSP; mst = M_IDLE; mcx = 0; mcy = 0; mdiv = YST; mys = YSP;
    mface = 1'b0; mjq = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j, input bit rs, input bit og, input bit hh);
    bit dv, rise, xs, ys, jend, lnd;
    int nx, ny, nst, ncx, ncy, ndiv, nys;
    dv = l ^ r;
    rise = j && !mjq;
    nx = mx; ny = my; nst = mst; ndiv = mdiv; nys = mys;
    xs = 1'b0;
    if (mst == M_IDLE || !dv) ncx = 0;
    else if (mcx == STEP - 1) begin ncx = 0; xs = 1'b1; end
    else ncx = mcx + 1;
    if (xs) begin
`ifdef PLAYER_MOTION_EDGE_CLAMP_EN
      if (!(r && mx == 1023 - 64 + 1) && !(l && mx == 0)) nx = r ? mx + 1 : mx - 1;
`else
      nx = (mx + (r ? 1 : 1023)) % 1024;
`endif
    end
    ys = 1'b0;
    if (mst == M_JUMP || mst == M_FALL) begin
      if (mcy == mdiv - 1) begin ys = 1'b1; ncy = 0; end
      else ncy = mcy + 1;
    end else ncy = 0;
    case (mst)
      M_IDLE, M_WALK: begin
        if (rise && og) begin nst = M_JUMP; nys = my; ndiv = YST; end
        else if (!og) begin nst = M_FALL; ndiv = YST; end
        else nst = dv ? M_WALK : M_IDLE;
      end
      M_JUMP: begin
        jend = (((mys - my + 1024) % 1024) >= JH) || hh || (my == 0);
        if (jend) nst = M_FALL;
        else if (ys) begin
          ny = my - 1;
          ndiv = (mdiv + YDD > 16777215) ? 16777215 : mdiv + YDD;
        end
      end
      default: begin
        lnd = og || (my >= YLIM);
        if (lnd) begin
          nst = M_IDLE;
          if (my > YLIM) ny = YLIM;
        end else if (ys) begin
          ny = my + 1;
          ndiv = (mdiv - YDD < YMIN) ? YMIN : mdiv - YDD;
        end
      end
    endcase
    if (nst != mst) ncy = 0;
    if (rs) begin nx = XSP; ny = YSP; nst = M_IDLE; ncx = 0; ncy = 0; ndiv = YST; end
    if (dv) mface = l;
    mjq = j;
    mx = nx; my = ny; mst = nst; mcx = ncx; mcy = ncy; mdiv = ndiv; mys = nys;
  endtask

  task automatic tick();
    on_ground = ground_at(mx, my);
    model_step(left, right, jump, respawn, on_ground, head_hit);
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    chk("x", x, mx);
    chk("y", y, my);
    chk("airborne", airborne, (mst == M_JUMP || mst == M_FALL) ? 1 : 0);
    chk("facing", facing, mface ? 1 : 0);
  endtask

  task automatic wait_land(input string tag);
    for (int c = 0; c < 300 && airborne; c++) tick();
    chk(tag, airborne, 0);
  endtask

  initial begin
    int cnt, k, prev_y;
    int iv[3];

    rst = 1'b1;
    right = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    edge_n = 0;
    chk("reset_x", x, XSP);
    chk("reset_y", y, YSP);
    chk("reset_airborne", airborne, 0);
    chk("reset_facing", facing, 0);

    // Right held from reset: first pixel STEP_DIV+1 edges after reset release.
    for (int i = 0; i < 9; i++) begin
      tick();
      if (edge_n == 1) chk("walk_x_e1", x, 500);
      if (edge_n == 5) begin
        chk("walk_x_e5", x, 501);
`ifdef PLAYER_MOTION_EDGE_CLAMP_EN
        chk("edge_left_x", ex, 0);
`else
        chk("edge_left_x", ex, 1023);
`endif
      end
      if (edge_n == 9) chk("walk_x_e9", x, 502);
    end
    chk("walk_facing", facing, 0);

    left = 1'b1;
    repeat (20) tick();
    chk("both_keys_x", x, 502);
    chk("both_keys_air", airborne, 0);
    left = 1'b0;
    right = 1'b0;
    repeat (2) tick();

    // Single jump pulse: pixel intervals 8, 10, 12 then fall back to the floor.
    jump = 1'b1;
    tick();
    jump = 1'b0;
    chk("jump_start_air", airborne, 1);
    cnt = 0; k = 0; prev_y = y;
    iv[0] = 0; iv[1] = 0; iv[2] = 0;
    for (int c = 0; c < 200 && k < 3; c++) begin
      tick();
      cnt++;
      if (y != prev_y) begin iv[k] = cnt; k++; cnt = 0; prev_y = y; end
    end
    chk("jump_iv0", iv[0], 8);
    chk("jump_iv1", iv[1], 10);
    chk("jump_iv2", iv[2], 12);
    chk("jump_peak_y", y, YSP - JH);
    wait_land("jump_land");
    chk("jump_land_y", y, YSP);

    // Jump held through landing must not re-trigger.
    jump = 1'b1;
    tick();
    wait_land("held_land");
    repeat (20) tick();
    chk("held_no_rejump", airborne, 0);
    jump = 1'b0;
    tick();
    jump = 1'b1;
    tick();
    chk("rejump_air", airborne, 1);
    jump = 1'b0;
    wait_land("rejump_land");

    // Ceiling one pixel into the jump: fall starts at once with the unchanged period of 10.
    jump = 1'b1;
    tick();
    jump = 1'b0;
    for (int c = 0; c < 40 && y != YSP - 1; c++) tick();
    chk("hh_reach_y", y, YSP - 1);
    head_hit = 1'b1;
    tick();
    head_hit = 1'b0;
    chk("hh_still_air", airborne, 1);
    cnt = 0;
    prev_y = y;
    for (int c = 0; c < 60 && y == prev_y; c++) begin tick(); cnt++; end
    chk("hh_fall_iv", cnt, 10);
    chk("hh_fall_y", y, YSP);
    wait_land("hh_land");

    // Random keys, ceiling hits and respawns over the holed terrain.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) left = ~left;
      if ($urandom_range(0, 7) == 0) right = ~right;
      if ($urandom_range(0, 5) == 0) jump = ~jump;
      respawn = ($urandom_range(0, 149) == 0);
      head_hit = ($urandom_range(0, 23) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Parametrised player movement controller: converts left/right/jump key levels plus collision flags into registered screen coordinates for one character sprite. Adds over the previous per-character controller: ground/ceiling collision inputs, jump edge detection, terminal fall velocity, respawn, facing output and screen-edge clamping. Sits between keyboard decode and collision map on the input side and the sprite draw pipeline on the output side; one instance per player.

## Interface
- COORD_W, 10, width of x/y
- X_SPAWN, 500, x after reset/respawn
- Y_SPAWN, 400, y after reset/respawn
- PLAYER_W, 64, sprite width in pixels
- PLAYER_H, 64, sprite height in pixels
- X_MIN, 0, leftmost allowed x
- X_MAX, 1023, rightmost allowed x + PLAYER_W - 1
- Y_FLOOR, 767, bottom screen row; y limit is Y_FLOOR - PLAYER_H
- JUMP_HEIGHT, 100, max rise in pixels
- STEP_DIV, 500_000, cycles per horizontal pixel
- Y_DIV_START, 500_000, cycles per vertical pixel at jump start / fall start
- Y_DIV_DELTA, 10_000, divider change per vertical pixel
- Y_DIV_MIN, 100_000, fall divider floor (terminal velocity)
- clk  in  1  system clock
- rst  in  1  reset
- left, right, jump  in  1 each  key levels, synchronous to clk
- respawn  in  1  return to spawn point
- on_ground  in  1  solid tile directly under feet at current x/y
- head_hit  in  1  solid tile directly above head at current x/y
- x, y  out  COORD_W each  sprite top-left corner
- airborne  out  1  state is JUMP or FALL
- facing  out  1  0 = right, 1 = left

One clock; reset is synchronous and active-high (clk, rst).

## Operation
- Reset: x=X_SPAWN, y=Y_SPAWN, state IDLE, all counters 0, ydiv=Y_DIV_START, facing=0, airborne=0, jump_q=0.
- dir_valid = left XOR right; both or neither = no horizontal motion, counter cx cleared. facing updates on any dir_valid cycle.
- jump_rise = jump & !jump_q; held jump never re-triggers; no jump while airborne.
- States: IDLE, WALK, JUMP, FALL. Priority each cycle: respawn > state rules.
- IDLE/WALK: jump_rise & on_ground -> JUMP (y_start=y, ydiv=Y_DIV_START, cy=0); else !on_ground -> FALL (ydiv=Y_DIV_START); else dir_valid -> WALK; else IDLE.
- JUMP: y-1 per vertical step, then ydiv += Y_DIV_DELTA (saturate at 2^24-1). -> FALL when (y_start - y) >= JUMP_HEIGHT, head_hit, or y == 0; ydiv retained on entry (symmetric arc).
- FALL: y+1 per vertical step, then ydiv = max(ydiv - Y_DIV_DELTA, Y_DIV_MIN). -> IDLE when on_ground or y >= Y_FLOOR - PLAYER_H; y then clamped to Y_FLOOR - PLAYER_H if exceeded.
- Horizontal stepping in WALK, JUMP, FALL (air control): cx counts 0..STEP_DIV-1; on cx==STEP_DIV-1 with dir_valid, x moves +/-1 and cx=0. IDLE holds cx=0.
- Vertical counter cy counts 0..ydiv-1; step on cy==ydiv-1. cy cleared on every state change.
- respawn: next edge x/y=spawn, IDLE, counters 0, ydiv=Y_DIV_START; facing kept.
- Arithmetic: jump rise computed as unsigned y_start - y (never y_start - JUMP_HEIGHT); counters 24 bit.

## Timing
- All outputs registered; input -> state change 1 edge.
- First x step: right asserted before edge 0 -> WALK at edge 1 -> x changes at edge STEP_DIV+1.
- First jump pixel: ydiv = Y_DIV_START cycles after JUMP entry.
- on_ground/head_hit sampled each cycle against current registered x/y; collision source must have <=1 cycle latency.
- Landing and jump_rise same cycle: land to IDLE first; jump acts on next qualifying rise.

## Configuration
- PLAYER_MOTION_EDGE_CLAMP_EN defined: x never below X_MIN or above X_MAX - PLAYER_W + 1; step blocked at limit, cx still cleared.
- Undefined: no horizontal clamp; x wraps modulo 2^COORD_W (0-1 -> 2^COORD_W-1).

## Structure
- game_pkg: motion_state_t enum (IDLE, WALK, JUMP, FALL), default screen/sprite constants shared with draw modules.
- Sub-module motion_step_timer: 24-bit counter with runtime limit, clear and enable, one-cycle step pulse; instantiated for x (limit STEP_DIV) and y (limit ydiv).

## Test plan
- Reset, STEP_DIV=4, on_ground=1, right held -> x=X_SPAWN at edge 1, 501 at edge 5, 502 at edge 9; facing=0.
- left and right both held 20 cycles -> x unchanged, state IDLE.
- Y_DIV_START=8, Y_DIV_DELTA=2, JUMP_HEIGHT=3, jump pulse on ground -> y falls by 1 after 8, 10, 12 cycles, then FALL; lands at Y_SPAWN on on_ground, airborne 0.
- Jump held through landing -> no second jump until jump deasserted and reasserted.
- head_hit asserted one pixel into jump -> FALL next edge, ydiv unchanged.
- Clamp enabled, X_SPAWN=X_MIN, left held -> x stays X_MIN; undefined -> x=1023 after one step.
